// File: rtl/t06_button_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module      : t06_button_conditioner_if
// Description : Control/status bundle between the raw push-buttons plus the
//               CPU step/gameover signals and the button conditioner.
//               master = stimulus side (buttons, tick, gameover, enable),
//               slave  = the conditioner itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface t06_button_conditioner_if;
    logic       enable;
    logic       button_right_in;
    logic       button_left_in;
    logic       button_up_in;
    logic       button_down_in;
    logic       button_start_pause_in;
    logic       move_tick;
    logic       gameover;
    logic [1:0] direction;
    logic       dir_changed;
    logic       running;
    logic       restart;

    modport master (
        output enable, button_right_in, button_left_in, button_up_in,
               button_down_in, button_start_pause_in, move_tick, gameover,
        input  direction, dir_changed, running, restart
    );

    modport slave (
        input  enable, button_right_in, button_left_in, button_up_in,
               button_down_in, button_start_pause_in, move_tick, gameover,
        output direction, dir_changed, running, restart
    );
endinterface
`default_nettype wire

// File: rtl/t06_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : t06_button_conditioner
// Description : Synchronises and debounces the five raw push-buttons, turns
//               debounced rising edges into one-cycle presses, filters snake
//               turns (repeats and reversals rejected) into a turn buffer that
//               is committed on move_tick, and runs the IDLE/RUN/PAUSE/OVER
//               game state machine with a restart pulse.
// Options     : T06_TURN_QUEUE_EN - when defined, the single overwriting turn
//               buffer becomes a 2-entry FIFO (one entry popped per tick).
// Note        : nrst is an active-HIGH asynchronous reset despite its name.
// Revision    : 1.0 - initial release
// ============================================================================
module t06_button_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  wire                     clk,
    input  wire                     nrst,
    t06_button_conditioner_if.slave bus
);
    localparam int               c_NBTN      = 5;
    localparam int               c_BTN_START = 4;
    localparam logic [CNT_W-1:0] c_CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    // Button order: 0 right, 1 left, 2 up, 3 down, 4 start/pause.
    // The index of a direction button equals its direction code.
    logic [c_NBTN-1:0] w_raw;
    logic [c_NBTN-1:0] w_press;

    assign w_raw = {bus.button_start_pause_in, bus.button_down_in,
                    bus.button_up_in, bus.button_left_in, bus.button_right_in};

    generate
        for (genvar gi = 0; gi < c_NBTN; gi++) begin : g_btn
            logic [SYNC_STAGES-1:0] sync_q;
            logic [CNT_W-1:0]       cnt_q;
            logic [CNT_W-1:0]       cnt_d;
            logic                   st_q;
            logic                   st_d;
            logic                   st_prev_q;
            logic                   w_s;

            assign w_s = sync_q[SYNC_STAGES-1];

            // Synchroniser keeps running while disabled so the level is fresh on re-enable.
            always_ff @(posedge clk or posedge nrst) begin
                if (nrst) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= {sync_q[SYNC_STAGES-2:0], w_raw[gi]};
                end
            end

            // Debounce: flip the stable level after DEBOUNCE_CYCLES consecutive mismatches.
            always_comb begin
                cnt_d = cnt_q;
                st_d  = st_q;
                if (w_s == st_q) begin
                    cnt_d = '0;
                end else if (cnt_q == c_CNT_LAST) begin
                    st_d  = w_s;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Debounce state and edge-detect history; frozen while the block is disabled.
            always_ff @(posedge clk or posedge nrst) begin
                if (nrst) begin
                    cnt_q     <= '0;
                    st_q      <= 1'b0;
                    st_prev_q <= 1'b0;
                end else if (bus.enable) begin
                    cnt_q     <= cnt_d;
                    st_q      <= st_d;
                    st_prev_q <= st_q;
                end
            end

            // A press survives a disabled stretch because st_prev is frozen with st.
            assign w_press[gi] = bus.enable & st_q & ~st_prev_q;
        end
    endgenerate

    logic       w_start;
    logic       w_cand_vld;
    logic [1:0] w_cand;

    assign w_start = w_press[c_BTN_START];

    // Fixed priority among simultaneous direction presses: right > left > up > down.
    always_comb begin
        w_cand_vld = |w_press[3:0];
        w_cand     = 2'b00;
        if (w_press[0]) begin
            w_cand = 2'b00;
        end else if (w_press[1]) begin
            w_cand = 2'b01;
        end else if (w_press[2]) begin
            w_cand = 2'b10;
        end else if (w_press[3]) begin
            w_cand = 2'b11;
        end
    end

    state_t     state_q;
    state_t     state_d;
    logic [1:0] dir_q;
    logic [1:0] dir_d;
    logic       dchg_q;
    logic       dchg_d;
    logic       restart_q;
    logic       restart_d;
    logic [1:0] w_ref;
    logic       w_accept;

`ifdef T06_TURN_QUEUE_EN
    logic [1:0] fifo_q [2];
    logic [1:0] fifo_d [2];
    logic [1:0] fcnt_q;
    logic [1:0] fcnt_d;
`else
    logic [1:0] pend_q;
    logic [1:0] pend_d;
    logic       pvld_q;
    logic       pvld_d;
`endif

    // Turn filtering, commit on move_tick and the game state machine.
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        dchg_d    = 1'b0;
        restart_d = 1'b0;
        w_ref     = dir_q;
`ifdef T06_TURN_QUEUE_EN
        fifo_d = fifo_q;
        fcnt_d = fcnt_q;
        // New turns are judged against the newest queued turn, if any.
        if (fcnt_q == 2'd2) begin
            w_ref = fifo_q[1];
        end else if (fcnt_q == 2'd1) begin
            w_ref = fifo_q[0];
        end
`else
        pend_d = pend_q;
        pvld_d = pvld_q;
`endif
        // Reverse direction = same axis (bit 1), opposite sign (bit 0 flipped).
        w_accept = w_cand_vld && (w_cand != w_ref) && (w_cand != {w_ref[1], ~w_ref[0]});

        if (state_q == S_RUN) begin
`ifdef T06_TURN_QUEUE_EN
            if (bus.move_tick && (fcnt_q != 2'd0)) begin
                dir_d     = fifo_q[0];
                dchg_d    = (fifo_q[0] != dir_q);
                fifo_d[0] = fifo_q[1];
                fcnt_d    = fcnt_q - 2'd1;
            end
            // Append after the pop, so a tick frees room for a same-cycle press.
            if (w_accept && (fcnt_d != 2'd2)) begin
                if (fcnt_d == 2'd0) begin
                    fifo_d[0] = w_cand;
                end else begin
                    fifo_d[1] = w_cand;
                end
                fcnt_d = fcnt_d + 2'd1;
            end
`else
            if (bus.move_tick && pvld_q) begin
                dir_d  = pend_q;
                dchg_d = (pend_q != dir_q);
                pvld_d = 1'b0;
            end
            // A newer accepted turn replaces whatever was buffered.
            if (w_accept) begin
                pend_d = w_cand;
                pvld_d = 1'b1;
            end
`endif
        end

        case (state_q)
            S_IDLE: begin
                if (w_start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.gameover) begin
                    state_d = S_OVER;
                end else if (w_start) begin
                    state_d = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (bus.gameover) begin
                    state_d = S_OVER;
                end else if (w_start) begin
                    state_d = S_RUN;
                end
            end
            S_OVER: begin
                if (w_start) begin
                    state_d   = S_IDLE;
                    restart_d = 1'b1;
                    dir_d     = 2'b00;
`ifdef T06_TURN_QUEUE_EN
                    fcnt_d = 2'd0;
`else
                    pvld_d = 1'b0;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Game state registers; everything holds while disabled and the pulses drop.
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            state_q   <= S_IDLE;
            dir_q     <= 2'b00;
            dchg_q    <= 1'b0;
            restart_q <= 1'b0;
`ifdef T06_TURN_QUEUE_EN
            fifo_q    <= '{default: 2'b00};
            fcnt_q    <= 2'd0;
`else
            pend_q    <= 2'b00;
            pvld_q    <= 1'b0;
`endif
        end else if (bus.enable) begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            dchg_q    <= dchg_d;
            restart_q <= restart_d;
`ifdef T06_TURN_QUEUE_EN
            fifo_q    <= fifo_d;
            fcnt_q    <= fcnt_d;
`else
            pend_q    <= pend_d;
            pvld_q    <= pvld_d;
`endif
        end else begin
            dchg_q    <= 1'b0;
            restart_q <= 1'b0;
        end
    end

    assign bus.direction   = dir_q;
    assign bus.dir_changed = dchg_q & bus.enable;
    assign bus.running     = (state_q == S_RUN);
    assign bus.restart     = restart_q & bus.enable;

endmodule
`default_nettype wire

// File: tb/tb_t06_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_t06_button_conditioner
// Description : Self-checking bench for t06_button_conditioner with
//               SYNC_STAGES=2, DEBOUNCE_CYCLES=4. A behavioural model (sample
//               history, debounce windows, turn queue) is compared with the
//               outputs every cycle; directed scenarios add literal checks,
//               followed by a randomized phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_t06_button_conditioner;
    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int CW   = 3;
`ifdef T06_TURN_QUEUE_EN
    localparam bit QMODE = 1'b1;
`else
    localparam bit QMODE = 1'b0;
`endif
    localparam int ST_IDLE = 0, ST_RUN = 1, ST_PAUSE = 2, ST_OVER = 3;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    t06_button_conditioner_if bus();

    t06_button_conditioner #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (CW)
    ) dut (
        .clk (clk),
        .nrst(nrst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- behavioural model ----------------
    bit [4:0] m_hist [SYNC];   // raw samples of previous edges, [0] newest
    bit       m_win  [5][$];   // last DEB enabled synchronised samples per button
    bit [4:0] m_st, m_stp;
    int       m_state;
    bit [1:0] m_dir;
    bit [1:0] m_q [$];         // buffered turns, oldest first
    bit       m_dc, m_rs;

    function automatic void m_reset();
        for (int k = 0; k < SYNC; k++) m_hist[k] = '0;
        for (int b = 0; b < 5; b++) m_win[b].delete();
        m_st = '0; m_stp = '0; m_state = ST_IDLE; m_dir = 2'b00;
        m_q.delete(); m_dc = 1'b0; m_rs = 1'b0;
    endfunction

    function automatic void m_step();
        bit [4:0] raw, press;
        bit [1:0] c, rf, nd;
        bit       cv, dc, rs, s, all_diff;
        raw = {bus.button_start_pause_in, bus.button_down_in, bus.button_up_in,
               bus.button_left_in, bus.button_right_in};
        if (bus.enable) begin
            press = m_st & ~m_stp;
            m_stp = m_st;
            // Stable level flips once DEB consecutive samples all disagree with it.
            for (int b = 0; b < 5; b++) begin
                s = m_hist[SYNC-1][b];
                m_win[b].push_back(s);
                if (m_win[b].size() > DEB) void'(m_win[b].pop_front());
                all_diff = (m_win[b].size() == DEB);
                for (int k = 0; k < m_win[b].size(); k++)
                    if (m_win[b][k] == m_st[b]) all_diff = 1'b0;
                if (all_diff) m_st[b] = s;
            end
            cv = 1'b0; c = 2'b00;
            for (int b = 3; b >= 0; b--) if (press[b]) begin cv = 1'b1; c = 2'(b); end
            dc = 1'b0; rs = 1'b0;
            if (m_state == ST_RUN) begin
                rf = m_dir;
                if (QMODE && m_q.size() > 0) rf = m_q[m_q.size()-1];
                if (bus.move_tick && m_q.size() > 0) begin
                    nd = m_q.pop_front(); dc = (nd != m_dir); m_dir = nd;
                end
                if (cv && c != rf && c != (rf ^ 2'b01)) begin
                    if (QMODE) begin
                        if (m_q.size() < 2) m_q.push_back(c);
                    end else begin
                        m_q.delete(); m_q.push_back(c);
                    end
                end
            end
            case (m_state)
                ST_IDLE:  if (press[4]) m_state = ST_RUN;
                ST_RUN:   if (bus.gameover) m_state = ST_OVER; else if (press[4]) m_state = ST_PAUSE;
                ST_PAUSE: if (bus.gameover) m_state = ST_OVER; else if (press[4]) m_state = ST_RUN;
                ST_OVER:  if (press[4]) begin m_state = ST_IDLE; rs = 1'b1; m_dir = 2'b00; m_q.delete(); end
                default:  ;
            endcase
            m_dc = dc; m_rs = rs;
        end else begin
            m_dc = 1'b0; m_rs = 1'b0;
        end
        for (int k = SYNC-1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = raw;
    endfunction

    always @(posedge clk or posedge nrst) begin
        if (nrst) m_reset();
        else      m_step();
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        logic [4:0] exp_o, got_o;
        exp_o = {m_dir, bus.enable & m_dc, (m_state == ST_RUN), bus.enable & m_rs};
        got_o = {bus.direction, bus.dir_changed, bus.running, bus.restart};
        n_cmp++;
        if (got_o !== exp_o) begin
            n_bad++;
            $display("FAIL outputs @%0t: got dir/chg/run/rst=%b expected %b", $time, got_o, exp_o);
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input int idx, input logic v);
        case (idx)
            0:       bus.button_right_in       = v;
            1:       bus.button_left_in        = v;
            2:       bus.button_up_in          = v;
            3:       bus.button_down_in        = v;
            default: bus.button_start_pause_in = v;
        endcase
    endtask

    task automatic push(input int idx);
        set_btn(idx, 1'b1); cyc(10);
        set_btn(idx, 1'b0); cyc(10);
    endtask

    task automatic do_tick(input string name, input logic [1:0] exp_dir, input logic exp_dc);
        bus.move_tick = 1'b1; cyc(1); bus.move_tick = 1'b0;
        check({name, "_dir"}, 8'(bus.direction), 8'(exp_dir));
        check({name, "_chg"}, 8'(bus.dir_changed), 8'(exp_dc));
        cyc(1);
        check({name, "_chg_off"}, 8'(bus.dir_changed), 8'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int nrs;
        int hold [5];
        logic [1:0] ovw_dir;
        bus.enable = 1'b1; bus.move_tick = 1'b0; bus.gameover = 1'b0;
        for (int b = 0; b < 5; b++) set_btn(b, 1'b0);
        #1 nrst = 1'b1;
        cyc(3);
        check("reset_dir", 8'(bus.direction), 8'd0);
        check("reset_chg", 8'(bus.dir_changed), 8'd0);
        check("reset_run", 8'(bus.running), 8'd0);
        check("reset_restart", 8'(bus.restart), 8'd0);
        nrst = 1'b0;
        cyc(2);
        check("idle_run", 8'(bus.running), 8'd0);
        push(4);
        check("start_run", 8'(bus.running), 8'd1);

        // 3-cycle glitch must not register
        set_btn(2, 1'b1); cyc(3); set_btn(2, 1'b0); cyc(10);
        do_tick("glitch", 2'b00, 1'b0);
        push(2); do_tick("up", 2'b10, 1'b1);
        push(0); do_tick("right", 2'b00, 1'b1);
        push(1); do_tick("rev_left", 2'b00, 1'b0);
        push(3); do_tick("down", 2'b11, 1'b1);
        push(0); do_tick("right2", 2'b00, 1'b1);

        // up then down before one tick
        ovw_dir = QMODE ? 2'b10 : 2'b11;
        push(2); push(3);
        do_tick("ovw1", ovw_dir, 1'b1);
        do_tick("ovw2", ovw_dir, 1'b0);

        // pause with a buffered turn
        push(0);
        push(4);
        check("pause_run", 8'(bus.running), 8'd0);
        do_tick("pause_tick", ovw_dir, 1'b0);
        push(4);
        check("resume_run", 8'(bus.running), 8'd1);
        check("model_state", 8'(m_state), 8'(ST_RUN));

        // game over and restart
        bus.gameover = 1'b1; cyc(1); bus.gameover = 1'b0;
        check("over_run", 8'(bus.running), 8'd0);
        check("over_dir", 8'(bus.direction), 8'(ovw_dir));
        set_btn(4, 1'b1);
        nrs = 0;
        repeat (16) begin
            @(negedge clk);
            if (bus.restart === 1'b1) nrs++;
        end
        @(posedge clk); #1;
        set_btn(4, 1'b0); cyc(10);
        check("restart_pulses", 8'(nrs), 8'd1);
        check("restart_dir", 8'(bus.direction), 8'd0);
        check("restart_run", 8'(bus.running), 8'd0);
        check("model_dir", 8'(m_dir), 8'd0);

        // async reset mid-debounce with a buffered turn
        push(4);
        push(2); do_tick("rst_up", 2'b10, 1'b1);
        push(1);
        set_btn(3, 1'b1); cyc(3);
        #1 nrst = 1'b1;
        #2;
        check("areset_dir", 8'(bus.direction), 8'd0);
        check("areset_run", 8'(bus.running), 8'd0);
        @(posedge clk); #1 nrst = 1'b0;
        set_btn(3, 1'b0); cyc(10);
        push(4);
        check("after_rst_run", 8'(bus.running), 8'd1);
        do_tick("after_rst", 2'b00, 1'b0);

        // randomized phase
        for (int b = 0; b < 5; b++) hold[b] = 0;
        for (int cy = 0; cy < 4000; cy++) begin
            for (int b = 0; b < 5; b++) begin
                if (hold[b] == 0) begin
                    set_btn(b, ($urandom_range(0, 2) == 0));
                    hold[b] = (b == 4) ? int'($urandom_range(1, 30)) : int'($urandom_range(1, 12));
                end else begin
                    hold[b]--;
                end
            end
            bus.move_tick = ($urandom_range(0, 5) == 0);
            bus.gameover  = ($urandom_range(0, 299) == 0);
            bus.enable    = ($urandom_range(0, 19) != 0);
            nrst          = ($urandom_range(0, 799) == 0);
            cyc(1);
        end
        bus.enable = 1'b1; nrst = 1'b0; bus.move_tick = 1'b0; bus.gameover = 1'b0;
        cyc(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
